// File: rtl/conv1_maxpool2x2_pkg.sv
// Shared constants and helpers for the conv-layer-1 pooling stage.
// Geometry/width defaults track the conv1 activation output plane.
package conv1_maxpool2x2_pkg;

    // conv1 activation plane geometry and pixel width
    localparam int CONV1_OUT_W = 24;
    localparam int CONV1_OUT_H = 24;
    localparam int ACT_DW      = 8;

    // Elaboration helper: a pooling dimension must be even and at least 2.
    function automatic bit pool_dim_ok(input int dim);
        return (dim >= 2) && ((dim % 2) == 0);
    endfunction

    // Signed max of two activation-width pixels; ties return the shared value.
    function automatic logic [ACT_DW-1:0] act_smax(input logic [ACT_DW-1:0] a,
                                                   input logic [ACT_DW-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

endpackage

// File: rtl/conv1_maxpool2x2_linebuf.sv
// Half-width line buffer for the 2x2 pool: holds the horizontal max of each
// column pair from the even row until the odd row completes the window.
// One synchronous write port, one asynchronous read port, no reset.
module conv1_pool_linebuf #(
    parameter int DEPTH = 12,
    parameter int DW    = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          nice_clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Write the even-row pair max; contents are always written before being read in a plane.
    always_ff @(posedge nice_clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/conv1_maxpool2x2.sv
// Streaming 2x2 / stride-2 signed max-pool after the conv1 activation.
// Raster-order pixels in, one registered pooled pixel out per 2x2 window.
// Only a half-width line buffer is kept; no frame storage.
module conv1_maxpool2x2
    import conv1_maxpool2x2_pkg::*;
#(
    parameter int IMG_W = CONV1_OUT_W,
    parameter int IMG_H = CONV1_OUT_H,
    parameter int DW    = ACT_DW
) (
    input  logic          nice_clk,
    input  logic          nice_rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB_D  = IMG_W / 2;
    localparam int AW    = (LB_D > 1) ? $clog2(LB_D) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    // Odd dimensions would leave half-windows; refuse to build.
    if (!pool_dim_ok(IMG_W)) begin : g_bad_w
        $error("conv1_maxpool2x2: IMG_W must be even and >= 2");
    end
    if (!pool_dim_ok(IMG_H)) begin : g_bad_h
        $error("conv1_maxpool2x2: IMG_H must be even and >= 2");
    end

    // Signed max at the configured pixel width.
    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;

    logic          in_fire;
    logic          col_odd, row_odd;
    logic          col_last, row_last;
    logic [DW-1:0] pair_max;
    logic [DW-1:0] lb_rdata;
    logic [DW-1:0] win_max;
    logic [AW-1:0] lb_addr;
    logic          lb_we;

    // Ready only looks at the output register and clr, never at in_valid.
    assign in_ready = ~clr & (~out_valid_q | out_ready);
    assign in_fire  = in_valid & in_ready;

    // Both dimensions are even, so bit 0 gives the in-window position.
    assign col_odd  = col_q[0];
    assign row_odd  = row_q[0];
    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);

    assign lb_addr  = AW'(col_q >> 1);
    assign pair_max = smax(hold_q, in_data);
    assign win_max  = smax(lb_rdata, pair_max);

    conv1_pool_linebuf #(
        .DEPTH (LB_D),
        .DW    (DW),
        .AW    (AW)
    ) u_linebuf (
        .nice_clk (nice_clk),
        .we_i     (lb_we),
        .waddr_i  (lb_addr),
        .wdata_i  (pair_max),
        .raddr_i  (lb_addr),
        .rdata_o  (lb_rdata)
    );

    // Next state: raster counters, pair hold, line-buffer write and output load/pop.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        lb_we       = 1'b0;

        // Pop first so a same-cycle load overwrites it without a bubble.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_fire) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d = row_last ? '0 : row_q + 1'b1;
            end

            if (!col_odd) begin
                hold_d = in_data;
            end else if (!row_odd) begin
                lb_we = 1'b1;
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = win_max;
                out_last_d  = row_last && col_last;
            end
        end

        // Plane restart drops any partial window and pending output.
        if (clr) begin
            col_d       = '0;
            row_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            lb_we       = 1'b0;
        end
    end

    // State registers; line buffer intentionally left out of reset.
    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv1_maxpool2x2.sv
// Directed and random checks of the 2x2 max-pool stage: a 4x4 instance for
// directed plane tests and a 24x24 instance for random frames against a
// reference pool computed from the stored frame.
module tb_conv1_maxpool2x2;

    logic gclk = 1'b0;
    always #5 gclk = ~gclk;

    logic            rst_n;
    logic [1:0]      clr, iv, ordy;
    logic [1:0][7:0] idat;
    wire  [1:0]      ir, ov, ol;
    wire  [1:0][7:0] od;

    int errors = 0;
    int checks = 0;

    // Scoreboards: {last, data}, one per instance.
    logic [8:0] q0[$];
    logic [8:0] q1[$];

    conv1_maxpool2x2 #(.IMG_W(4), .IMG_H(4), .DW(8)) u_dut4 (
        .nice_clk(gclk), .nice_rst_n(rst_n), .clr(clr[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_last(ol[0]));

    conv1_maxpool2x2 #(.IMG_W(24), .IMG_H(24), .DW(8)) u_dut24 (
        .nice_clk(gclk), .nice_rst_n(rst_n), .clr(clr[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_last(ol[1]));

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic last, input logic [7:0] v);
        if (d == 0) q0.push_back({last, v});
        else        q1.push_back({last, v});
    endtask

    // Called at a negedge with inputs set: reports whether the coming edge
    // accepts a pixel, and scores any output handed over on that edge.
    task automatic sample(input int d, output bit fire);
        logic [8:0] e;
        int sz;
        #1;
        fire = iv[d] && ir[d];
        if (ov[d] && ordy[d]) begin
            sz = (d == 0) ? q0.size() : q1.size();
            chk("sb_output_expected", (sz > 0), 1);
            if (sz > 0) begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk("out_data", $signed(od[d]), $signed(e[7:0]));
                chk("out_last", ol[d], e[8]);
            end
        end
    endtask

    task automatic beat(input int d, input logic [7:0] v);
        bit f;
        int n;
        n = 0;
        iv[d]   = 1'b1;
        idat[d] = v;
        sample(d, f);
        while (!f && n < 100) begin
            @(negedge gclk);
            n++;
            sample(d, f);
        end
        chk("beat_accepted", f, 1);
        @(negedge gclk);
    endtask

    task automatic idle(input int d, input int n);
        bit f;
        iv[d] = 1'b0;
        repeat (n) begin
            sample(d, f);
            @(negedge gclk);
        end
    endtask

    task automatic ramp4(input int base);
        for (int i = 0; i < 16; i++) beat(0, 8'(base + i));
    endtask

    task automatic push_ramp4(input int base);
        push(0, 1'b0, 8'(base + 5));
        push(0, 1'b0, 8'(base + 7));
        push(0, 1'b0, 8'(base + 13));
        push(0, 1'b1, 8'(base + 15));
    endtask

    // Stops a hung run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    logic [7:0]        px   [16];
    logic [7:0]        pix  [576];
    logic signed [7:0] m;
    bit                f;
    int                idx, guard;

    initial begin
        rst_n = 1'b0;
        clr   = '0;
        iv    = '0;
        ordy  = 2'b11;
        idat  = '0;
        @(negedge gclk);
        #1;
        // reset state
        chk("rst_out_valid", ov[0], 0);
        chk("rst_out_data", od[0], 0);
        chk("rst_out_last", ol[0], 0);
        chk("rst_in_ready", ir[0], 1);
        chk("rst_out_valid24", ov[1], 0);
        @(negedge gclk);
        rst_n = 1'b1;
        @(negedge gclk);

        // 1: ramp 0..15, out_valid one cycle after pixels 5,7,13,15
        push_ramp4(0);
        for (int i = 0; i < 16; i++) begin
            iv[0]   = 1'b1;
            idat[0] = 8'(i);
            sample(0, f);
            chk("t1_in_ready", ir[0], 1);
            chk("t1_lat_valid", ov[0], (i == 6 || i == 8 || i == 14));
            @(negedge gclk);
        end
        iv[0] = 1'b0;
        sample(0, f);
        chk("t1_lat_valid_last", ov[0], 1);
        @(negedge gclk);
        sample(0, f);
        chk("t1_valid_drops", ov[0], 0);
        @(negedge gclk);
        chk("t1_sb_empty", q0.size(), 0);

        // 2: signed windows; stale ramp values in lbuf must not leak
        px = '{8'h80, 8'hFB, 8'hFF, 8'h00,
               8'hF9, 8'h80, 8'h80, 8'hFE,
               8'h80, 8'h80, 8'h7F, 8'h80,
               8'h80, 8'h80, 8'h03, 8'hFF};
        push(0, 1'b0, 8'hFB);
        push(0, 1'b0, 8'h00);
        push(0, 1'b0, 8'h80);
        push(0, 1'b1, 8'h7F);
        for (int i = 0; i < 16; i++) beat(0, px[i]);
        idle(0, 3);
        chk("t2_sb_empty", q0.size(), 0);

        // 3: backpressure for 5 cycles after the first output
        push_ramp4(0);
        for (int i = 0; i < 6; i++) beat(0, 8'(i));
        ordy[0] = 1'b0;
        iv[0]   = 1'b1;
        idat[0] = 8'd6;
        repeat (5) begin
            sample(0, f);
            chk("t3_in_ready_low", ir[0], 0);
            chk("t3_valid_held", ov[0], 1);
            chk("t3_data_held", $signed(od[0]), 5);
            @(negedge gclk);
        end
        ordy[0] = 1'b1;
        for (int i = 6; i < 16; i++) beat(0, 8'(i));
        idle(0, 3);
        chk("t3_sb_empty", q0.size(), 0);

        // 4: two planes back to back
        push_ramp4(0);
        push_ramp4(16);
        for (int i = 0; i < 32; i++) beat(0, 8'(i));
        idle(0, 3);
        chk("t4_sb_empty", q0.size(), 0);

        // 5a: clr mid row 1 with a completed window still pending
        ordy[0] = 1'b0;
        for (int i = 0; i < 6; i++) beat(0, 8'(i));
        iv[0]  = 1'b0;
        clr[0] = 1'b1;
        sample(0, f);
        chk("t5_clr_in_ready", ir[0], 0);
        @(negedge gclk);
        iv[0]   = 1'b1;
        idat[0] = 8'h55;
        ordy[0] = 1'b1;
        sample(0, f);
        chk("t5_clr_out_valid", ov[0], 0);
        chk("t5_clr_forces_ready", ir[0], 0);
        @(negedge gclk);
        clr[0] = 1'b0;
        push_ramp4(0);
        ramp4(0);
        idle(0, 3);
        chk("t5_clr_sb_empty", q0.size(), 0);

        // 5b: same with an asynchronous reset pulse
        ordy[0] = 1'b0;
        for (int i = 0; i < 6; i++) beat(0, 8'(i));
        iv[0] = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("t5_rst_out_valid", ov[0], 0);
        chk("t5_rst_out_last", ol[0], 0);
        chk("t5_rst_out_data", od[0], 0);
        rst_n = 1'b1;
        @(negedge gclk);
        ordy[0] = 1'b1;
        push_ramp4(0);
        ramp4(0);
        idle(0, 3);
        chk("t5_rst_sb_empty", q0.size(), 0);

        // 6: random signed 24x24 planes, random valid/ready
        for (int p = 0; p < 16; p++) begin
            for (int i = 0; i < 576; i++) pix[i] = 8'($urandom);
            for (int r = 0; r < 12; r++) begin
                for (int c = 0; c < 12; c++) begin
                    m = pix[(2 * r) * 24 + 2 * c];
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++)
                            if ($signed(pix[(2 * r + dr) * 24 + 2 * c + dc]) > m)
                                m = pix[(2 * r + dr) * 24 + 2 * c + dc];
                    push(1, (r == 11 && c == 11), m);
                end
            end
            idx   = 0;
            guard = 0;
            while (idx < 576 && guard < 20000) begin
                iv[1]   = 1'($urandom_range(1, 0));
                idat[1] = pix[idx];
                ordy[1] = 1'($urandom_range(1, 0));
                sample(1, f);
                if (f) idx++;
                guard++;
                @(negedge gclk);
            end
            chk("t6_plane_consumed", idx, 576);
        end
        ordy[1] = 1'b1;
        idle(1, 10);
        chk("t6_sb_empty", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
